// File: rtl/tcdm_init_pkg.sv
// Shared types for the TCDM bulk-initialisation initiator.
package tcdm_init_pkg;

    // Default field widths; the top-level parameters default to these values.
    localparam int unsigned CFG_ADDR_WIDTH = 32;
    localparam int unsigned CFG_DATA_WIDTH = 32;
    localparam int unsigned CFG_CNT_WIDTH  = 16;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_e;

    // Job configuration captured when a start is accepted.
    typedef struct packed {
        logic [CFG_ADDR_WIDTH-1:0] base;
        logic [CFG_CNT_WIDTH-1:0]  num_words;
        logic [CFG_DATA_WIDTH-1:0] pattern;
        logic                      addr_mix;
        logic                      check;
    } cfg_t;

endpackage

// File: rtl/tcdm_init_rchk.sv
// Read-check pipeline: registers the expected word of each granted read,
// compares it with the response one cycle later and keeps the first error address.
module tcdm_init_rchk #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  flush_i,
    input  logic                  fire_i,
    input  logic [DATA_WIDTH-1:0] exp_data_i,
    input  logic [ADDR_WIDTH-1:0] exp_addr_i,
    input  logic [DATA_WIDTH-1:0] r_data_i,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o
);

    logic                  rvld_q;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [ADDR_WIDTH-1:0] eaddr_q;
    logic                  mismatch;

    // A flushed (aborted) response is never compared.
    assign mismatch = rvld_q && !flush_i && (r_data_i != exp_q);

    // Track which granted read returns data next cycle and what it should contain.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvld_q  <= 1'b0;
            exp_q   <= '0;
            eaddr_q <= '0;
        end else begin
            rvld_q <= fire_i && !flush_i;
            if (fire_i && !flush_i) begin
                exp_q   <= exp_data_i;
                eaddr_q <= exp_addr_i;
            end
        end
    end

    // Sticky error flag; only the first mismatch address of a job is kept.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end else if (clear_i) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end else if (mismatch) begin
            err_o <= 1'b1;
            if (!err_o) begin
                err_addr_o <= eaddr_q;
            end
        end
    end

endmodule

// File: rtl/tcdm_init_master.sv
// TCDM initiator that fills a contiguous word range with a pattern and can
// read it back to report the first mismatching word.
module tcdm_init_master
    import tcdm_init_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = CFG_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = CFG_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = CFG_CNT_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [CNT_WIDTH-1:0]    num_words_i,
    input  logic [DATA_WIDTH-1:0]   pattern_i,
    input  logic                    addr_mix_i,
    input  logic                    check_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [ADDR_WIDTH-1:0]   err_addr_o,
    output logic                    tcdm_req_o,
    input  logic                    tcdm_gnt_i,
    output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
    output logic                    tcdm_wen_o,
    output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
    output logic [DATA_WIDTH-1:0]   tcdm_data_o,
    input  logic [DATA_WIDTH-1:0]   tcdm_r_data_i
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    state_e                state_q, state_d;
    cfg_t                  cfg_q, cfg_d;
    logic [CNT_WIDTH-1:0]  idx_q, idx_d;
    logic                  start_acc;
    logic                  last_word;
    logic                  read_fire;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [DATA_WIDTH-1:0] word_data;

    // Base bits [1:0] are masked off; the sum wraps modulo 2^ADDR_WIDTH.
    assign word_addr = (ADDR_WIDTH'(cfg_q.base) & ~ADDR_WIDTH'(3))
                     + (ADDR_WIDTH'(idx_q) << 2);
    assign word_data = DATA_WIDTH'(cfg_q.pattern)
                     ^ (cfg_q.addr_mix ? DATA_WIDTH'(word_addr) : '0);
    assign last_word = (idx_q == (CNT_WIDTH'(cfg_q.num_words) - CNT_WIDTH'(1)));
    assign read_fire = (state_q == READ) && tcdm_gnt_i;

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);

    // State, word index and captured job configuration.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cfg_q   <= cfg_d;
        end
    end

    // Next-state logic; abort overrides everything, including a start in IDLE.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cfg_d     = cfg_q;
        start_acc = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        start_acc       = 1'b1;
                        cfg_d.base      = CFG_ADDR_WIDTH'(base_addr_i);
                        cfg_d.num_words = CFG_CNT_WIDTH'(num_words_i);
                        cfg_d.pattern   = CFG_DATA_WIDTH'(pattern_i);
                        cfg_d.addr_mix  = addr_mix_i;
                        cfg_d.check     = check_i;
                        idx_d           = '0;
                        state_d         = (num_words_i == '0) ? DONE : WRITE;
                    end
                end
                WRITE: begin
                    if (tcdm_gnt_i) begin
                        if (last_word) begin
                            idx_d   = '0;
                            state_d = cfg_q.check ? READ : DONE;
                        end else begin
                            idx_d = idx_q + CNT_WIDTH'(1);
                        end
                    end
                end
                READ: begin
                    if (tcdm_gnt_i) begin
                        if (last_word) begin
                            idx_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            idx_d = idx_q + CNT_WIDTH'(1);
                        end
                    end
                end
                DRAIN:   state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Request-side outputs are a pure function of state, so they hold through stalls.
    always_comb begin
        tcdm_req_o  = 1'b0;
        tcdm_wen_o  = 1'b1;
        tcdm_be_o   = '0;
        tcdm_add_o  = '0;
        tcdm_data_o = '0;
        case (state_q)
            WRITE: begin
                tcdm_req_o  = 1'b1;
                tcdm_wen_o  = 1'b0;
                tcdm_be_o   = {BE_WIDTH{1'b1}};
                tcdm_add_o  = word_addr;
                tcdm_data_o = word_data;
            end
            READ: begin
                tcdm_req_o = 1'b1;
                tcdm_be_o  = {BE_WIDTH{1'b1}};
                tcdm_add_o = word_addr;
            end
            default: ;
        endcase
    end

    tcdm_init_rchk #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rchk (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (start_acc),
        .flush_i    (abort_i),
        .fire_i     (read_fire),
        .exp_data_i (word_data),
        .exp_addr_i (word_addr),
        .r_data_i   (tcdm_r_data_i),
        .err_o      (err_o),
        .err_addr_o (err_addr_o)
    );

endmodule

// File: tb/tb_tcdm_init_master.sv
// Scoreboard bench for tcdm_init_master: expected bus transfers and job results
// are queued at stimulus time and popped by a monitor as the DUT produces them.
module tb_tcdm_init_master;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] base_addr;
    logic [15:0] num_words;
    logic [31:0] pattern;
    logic        addr_mix;
    logic        check;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] err_addr;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] data;
    } txn_t;

    typedef struct packed {
        logic        err;
        logic [31:0] err_addr;
    } res_t;

    txn_t        exp_txn[$];
    res_t        exp_res[$];
    logic [31:0] mem[logic [31:0]];
    bit          corrupt[logic [31:0]];

    int checks = 0;
    int errors = 0;
    int gnt_mode = 0;
    int active_cycles;
    int waited_cycles;

    tcdm_init_master dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .abort_i       (abort),
        .base_addr_i   (base_addr),
        .num_words_i   (num_words),
        .pattern_i     (pattern),
        .addr_mix_i    (addr_mix),
        .check_i       (check),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .err_addr_o    (err_addr),
        .tcdm_req_o    (req),
        .tcdm_gnt_i    (gnt),
        .tcdm_add_o    (add),
        .tcdm_wen_o    (wen),
        .tcdm_be_o     (be),
        .tcdm_data_o   (wdata),
        .tcdm_r_data_i (rdata)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Queue the expected transfers, then pulse start for one cycle.
    task automatic applyStimulus(input logic [31:0] b, input logic [15:0] n,
                                 input logic [31:0] pat, input bit mix, input bit chk,
                                 input logic [31:0] addrs[4]);
        txn_t t;
        for (int i = 0; i < int'(n); i++) begin
            t.addr = addrs[i];
            t.wen  = 1'b0;
            t.data = mix ? (pat ^ addrs[i]) : pat;
            exp_txn.push_back(t);
        end
        if (chk) begin
            for (int i = 0; i < int'(n); i++) begin
                t.addr = addrs[i];
                t.wen  = 1'b1;
                t.data = 32'h0;
                exp_txn.push_back(t);
            end
        end
        @(posedge clk); #1;
        base_addr = b;
        num_words = n;
        pattern   = pat;
        addr_mix  = mix;
        check     = chk;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic waitDone(input int maxc, output int active, output int waited);
        bit found;
        found  = 0;
        active = 0;
        waited = 0;
        for (int w = 1; w <= maxc; w++) begin
            @(negedge clk);
            if (done) begin
                waited = w;
                found  = 1;
                break;
            end
            if (busy) active++;
        end
        if (!found) begin
            errors++;
            $display("[TB] FAIL done_timeout: got no done_o within %0d cycles, expected a pulse", maxc);
        end
    endtask

    // Grant driver: always granted, alternating, or held low.
    initial begin
        bit tog;
        tog = 1'b0;
        gnt = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (gnt_mode)
                0: gnt = 1'b1;
                1: begin gnt = tog; tog = ~tog; end
                default: gnt = 1'b0;
            endcase
        end
    end

    // Memory model: answers a granted read one cycle later, optionally flipping bit 3.
    initial begin
        bit          rd_pend;
        logic [31:0] rd_addr;
        logic [31:0] v;
        rdata = 32'hDEADBEEF;
        forever begin
            @(negedge clk);
            rd_pend = req && gnt && wen;
            rd_addr = add;
            @(posedge clk); #1;
            if (rd_pend) begin
                v = mem.exists(rd_addr) ? mem[rd_addr] : 32'h0;
                if (corrupt.exists(rd_addr)) v = v ^ 32'h8;
                rdata = v;
            end else begin
                rdata = 32'hDEADBEEF;
            end
        end
    end

    // Monitor: pops the scoreboard on each transfer and each done pulse, checks stall stability.
    initial begin
        txn_t        t;
        res_t        r;
        bit          stall_pend;
        logic [31:0] hold_add;
        logic [31:0] hold_data;
        logic        hold_wen;
        stall_pend = 0;
        hold_add   = '0;
        hold_data  = '0;
        hold_wen   = 1'b0;
        @(posedge rst_n);
        forever begin
            @(negedge clk);
            if (stall_pend) begin
                checkOutput("stall_req", req, 1);
                checkOutput("stall_add", add, hold_add);
                checkOutput("stall_wen", wen, hold_wen);
                if (!hold_wen) checkOutput("stall_data", wdata, hold_data);
            end
            stall_pend = req && !gnt && !abort;
            hold_add   = add;
            hold_data  = wdata;
            hold_wen   = wen;
            if (req && gnt) begin
                if (exp_txn.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_txn: got transfer at 0x%0h wen=%0b, expected none", add, wen);
                end else begin
                    t = exp_txn.pop_front();
                    checkOutput("txn_addr", add, t.addr);
                    checkOutput("txn_wen", wen, t.wen);
                    checkOutput("txn_be", be, 4'hF);
                    if (!t.wen) checkOutput("txn_data", wdata, t.data);
                end
                if (!wen) mem[add] = wdata;
            end
            if (done) begin
                if (exp_res.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done_o=1, expected 0");
                end else begin
                    r = exp_res.pop_front();
                    checkOutput("done_err", err, r.err);
                    checkOutput("done_err_addr", err_addr, r.err_addr);
                end
            end
        end
    end

    // Watchdog in case a wait is ever unbounded.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        res_t r;
        bit   seen;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        num_words = '0;
        pattern   = '0;
        addr_mix  = 1'b0;
        check     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_req", req, 0);
        checkOutput("rst_wen", wen, 1);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_err_addr", err_addr, 0);
        checkOutput("rst_add", add, 0);
        checkOutput("rst_be", be, 0);
        rst_n = 1'b1;

        $display("[TB] test 1: plain fill");
        r.err = 1'b0; r.err_addr = 32'h0; exp_res.push_back(r);
        applyStimulus(32'h100, 16'd4, 32'hA5A5A5A5, 1'b0, 1'b0,
                      '{32'h100, 32'h104, 32'h108, 32'h10C});
        checkOutput("t1_first_req", req, 1);
        waitDone(20, active_cycles, waited_cycles);
        checkOutput("t1_active_cycles", active_cycles, 4);
        checkOutput("t1_done_at", waited_cycles, 5);
        @(negedge clk);
        checkOutput("t1_done_one_cycle", done, 0);
        checkOutput("t1_idle_busy", busy, 0);

        $display("[TB] test 2: grant stall");
        gnt_mode = 1;
        r.err = 1'b0; r.err_addr = 32'h0; exp_res.push_back(r);
        applyStimulus(32'h100, 16'd4, 32'hA5A5A5A5, 1'b0, 1'b0,
                      '{32'h100, 32'h104, 32'h108, 32'h10C});
        waitDone(40, active_cycles, waited_cycles);
        checkOutput("t2_all_writes_seen", exp_txn.size(), 0);
        gnt_mode = 0;

        $display("[TB] test 3: check mode with corrupted words");
        corrupt[32'h108] = 1;
        corrupt[32'h10C] = 1;
        r.err = 1'b1; r.err_addr = 32'h108; exp_res.push_back(r);
        applyStimulus(32'h100, 16'd4, 32'h12345678, 1'b1, 1'b1,
                      '{32'h100, 32'h104, 32'h108, 32'h10C});
        waitDone(40, active_cycles, waited_cycles);
        checkOutput("t3_active_cycles", active_cycles, 9);
        @(negedge clk);
        checkOutput("t3_err_sticky", err, 1);
        checkOutput("t3_err_addr_sticky", err_addr, 32'h108);
        corrupt.delete();

        $display("[TB] test 4: abort during read");
        corrupt[32'h100] = 1;
        corrupt[32'h104] = 1;
        applyStimulus(32'h100, 16'd4, 32'h0F0F0F0F, 1'b0, 1'b1,
                      '{32'h100, 32'h104, 32'h108, 32'h10C});
        checkOutput("t4_err_cleared", err, 0);
        checkOutput("t4_err_addr_cleared", err_addr, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req && gnt && wen) begin
                seen = 1;
                break;
            end
        end
        checkOutput("t4_read_granted", seen, 1);
        gnt_mode = 2;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("t4_req_dropped", req, 0);
        checkOutput("t4_busy_dropped", busy, 0);
        repeat (3) @(negedge clk);
        checkOutput("t4_no_late_compare", err, 0);
        checkOutput("t4_pending_reads", exp_txn.size(), 3);
        exp_txn.delete();
        corrupt.delete();
        gnt_mode = 0;

        $display("[TB] test 4b: abort beats start in idle");
        @(posedge clk); #1;
        base_addr = 32'h200; num_words = 16'd2; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        checkOutput("t4b_busy", busy, 0);
        checkOutput("t4b_req", req, 0);

        $display("[TB] test 5: zero-length job");
        r.err = 1'b0; r.err_addr = 32'h0; exp_res.push_back(r);
        applyStimulus(32'h300, 16'd0, 32'h11111111, 1'b0, 1'b1,
                      '{32'h0, 32'h0, 32'h0, 32'h0});
        checkOutput("t5_no_req", req, 0);
        waitDone(10, active_cycles, waited_cycles);
        checkOutput("t5_done_at", waited_cycles, 1);
        checkOutput("t5_active_cycles", active_cycles, 0);

        $display("[TB] test 6: address wrap, restart ignored while busy");
        r.err = 1'b0; r.err_addr = 32'h0; exp_res.push_back(r);
        applyStimulus(32'hFFFFFFF8, 16'd4, 32'hCAFEF00D, 1'b1, 1'b1,
                      '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004});
        base_addr = 32'h500;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        waitDone(40, active_cycles, waited_cycles);
        repeat (3) @(negedge clk);
        checkOutput("t6_all_txns_seen", exp_txn.size(), 0);
        checkOutput("t6_all_results_seen", exp_res.size(), 0);
        checkOutput("t6_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
